// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared CP0 constants: register numbers, ExcCode values, exception entry vector.
// Consumers: cp0_exc_ctrl and the D-stage next-PC logic (build option CP0_EPC_BYPASS_EN lives in the top).
package cp0_exc_ctrl_pkg;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] EXC_ENTRY_ADDR = 32'h0000_4180;

    // Bit positions shared by SR and Cause
    localparam int SR_IE_BIT     = 0;
    localparam int SR_EXL_BIT    = 1;
    localparam int IM_IP_LSB     = 10;
    localparam int CAUSE_EXC_LSB = 2;
    localparam int CAUSE_BD_BIT  = 31;

    // Restart address: a delay-slot victim restarts at its branch.
    function automatic logic [31:0] epc_of(input logic [31:0] vpc, input logic bd);
        return bd ? (vpc - 32'd4) : vpc;
    endfunction

endpackage

// File: rtl/cp0_exc_ctrl_if.sv
// M-stage <-> CP0 signal bundle; slave is the CP0 side, master the pipeline side.
interface cp0_exc_ctrl_if #(
    parameter int HWINT_W = 6
);
    logic [4:0]         A1;
    logic [4:0]         A2;
    logic [31:0]        DIn;
    logic               WE;
    logic [31:0]        VPC;
    logic               BDIn;
    logic [4:0]         ExcCodeIn;
    logic [HWINT_W-1:0] HWInt;
    logic               EXLClr;
    logic [31:0]        DOut;
    logic [31:0]        EPCOut;
    logic               Req;

    modport master (
        output A1, A2, DIn, WE, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
        input  DOut, EPCOut, Req
    );

    modport slave (
        input  A1, A2, DIn, WE, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
        output DOut, EPCOut, Req
    );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller: SR, Cause, EPC, PRId plus the Req decision.
// Define CP0_EPC_BYPASS_EN to forward an in-flight mtc0 EPC value onto EPCOut.
module cp0_exc_ctrl
    import cp0_exc_ctrl_pkg::*;
#(
    parameter logic [31:0] PRID_VALUE = 32'h2023_0007,
    parameter int          HWINT_W    = 6
) (
    input  logic          clk,
    input  logic          reset_n,
    cp0_exc_ctrl_if.slave bus
);

    logic [HWINT_W-1:0] r_im;
    logic               r_exl;
    logic               r_ie;
    logic               r_bd;
    logic [HWINT_W-1:0] r_ip;
    logic [4:0]         r_exccode;
    logic [31:0]        r_epc;

    logic        w_int_req;
    logic        w_exc_req;
    logic        w_req;
    logic        w_wr_sr;
    logic        w_wr_epc;
    logic [31:0] w_dout;
    logic [31:0] w_epc_out;

    // EXL masks both sources, so a handler is never re-entered.
    assign w_int_req = (|(bus.HWInt & r_im)) & r_ie & ~r_exl;
    assign w_exc_req = (bus.ExcCodeIn != EXC_INT) & ~r_exl;
    assign w_req     = w_int_req | w_exc_req;

    assign w_wr_sr  = bus.WE & ~w_req & (bus.A2 == CP0_SR);
    assign w_wr_epc = bus.WE & ~w_req & (bus.A2 == CP0_EPC);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_im      <= '0;
            r_exl     <= 1'b0;
            r_ie      <= 1'b0;
            r_bd      <= 1'b0;
            r_ip      <= '0;
            r_exccode <= '0;
            r_epc     <= '0;
        end else begin
            r_ip <= bus.HWInt;
            if (w_req) begin
                r_exl     <= 1'b1;
                r_bd      <= bus.BDIn;
                r_exccode <= w_int_req ? EXC_INT : bus.ExcCodeIn;
                r_epc     <= epc_of(bus.VPC, bus.BDIn);
            end else begin
                if (bus.EXLClr)
                    r_exl <= 1'b0;
                // Later assignment: an mtc0 SR in the eret cycle sets EXL from DIn.
                if (w_wr_sr) begin
                    r_im  <= bus.DIn[IM_IP_LSB +: HWINT_W];
                    r_exl <= bus.DIn[SR_EXL_BIT];
                    r_ie  <= bus.DIn[SR_IE_BIT];
                end
                if (w_wr_epc)
                    r_epc <= bus.DIn;
            end
        end
    end

    always_comb begin
        w_dout = '0;
        case (bus.A1)
            CP0_SR: begin
                w_dout[IM_IP_LSB +: HWINT_W] = r_im;
                w_dout[SR_EXL_BIT]           = r_exl;
                w_dout[SR_IE_BIT]            = r_ie;
            end
            CP0_CAUSE: begin
                w_dout[CAUSE_BD_BIT]              = r_bd;
                w_dout[IM_IP_LSB +: HWINT_W]      = r_ip;
                w_dout[CAUSE_EXC_LSB +: 5]        = r_exccode;
            end
            CP0_EPC:  w_dout = r_epc;
            CP0_PRID: w_dout = PRID_VALUE;
            default:  w_dout = '0;
        endcase
    end

`ifdef CP0_EPC_BYPASS_EN
    assign w_epc_out = w_wr_epc ? bus.DIn : r_epc;
`else
    // Without forwarding the hazard unit stalls eret behind an mtc0 EPC.
    assign w_epc_out = r_epc;
`endif

    assign bus.DOut   = w_dout;
    assign bus.EPCOut = w_epc_out;
    assign bus.Req    = w_req;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed vector table, async-reset sequence, then random traffic against a word-level CP0 model.
module tb_cp0_exc_ctrl;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cp0_exc_ctrl_if #(.HWINT_W(6)) bus ();

    cp0_exc_ctrl #(.PRID_VALUE(32'h2023_0007), .HWINT_W(6)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    typedef struct {
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] din;
        logic        we;
        logic [31:0] vpc;
        logic        bd;
        logic [4:0]  code;
        logic [5:0]  hw;
        logic        clr;
        logic        req;
        logic [31:0] dout;
        logic [31:0] epc;
    } vec_t;

    vec_t tbl[24];

    function automatic vec_t mk(logic [4:0] a1, logic [4:0] a2, logic [31:0] din, logic we,
                                logic [31:0] vpc, logic bd, logic [4:0] code, logic [5:0] hw,
                                logic clr, logic req, logic [31:0] dout, logic [31:0] epc);
        vec_t v;
        v.a1 = a1; v.a2 = a2; v.din = din; v.we = we; v.vpc = vpc; v.bd = bd;
        v.code = code; v.hw = hw; v.clr = clr; v.req = req; v.dout = dout; v.epc = epc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.A1 = v.a1; bus.A2 = v.a2; bus.DIn = v.din; bus.WE = v.we;
        bus.VPC = v.vpc; bus.BDIn = v.bd; bus.ExcCodeIn = v.code;
        bus.HWInt = v.hw; bus.EXLClr = v.clr;
    endtask

    // Word-level model: SR, Cause, EPC held as architectural 32-bit values.
    logic [31:0] m_sr, m_cause, m_epc;
    localparam logic [31:0] SR_MASK = 32'h0000_FC03;

    function automatic bit m_int();
        return ((bus.HWInt & m_sr[15:10]) != 0) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic bit m_req();
        return m_int() || ((bus.ExcCodeIn != 0) && !m_sr[1]);
    endfunction

    function automatic logic [31:0] m_dout();
        case (bus.A1)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return 32'h2023_0007;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_epcout();
`ifdef CP0_EPC_BYPASS_EN
        if (bus.WE && !m_req() && bus.A2 == 5'd14) return bus.DIn;
`endif
        return m_epc;
    endfunction

    task automatic m_step();
        bit intr, req;
        intr = m_int();
        req  = m_req();
        m_cause = (m_cause & ~32'h0000_FC00) | ({26'd0, bus.HWInt} << 10);
        if (req) begin
            m_sr    = m_sr | 32'h2;
            m_cause = (m_cause & 32'h0000_FC00) | (bus.BDIn ? 32'h8000_0000 : 32'h0)
                    | (intr ? 32'h0 : ({27'd0, bus.ExcCodeIn} << 2));
            m_epc   = bus.VPC - (bus.BDIn ? 32'd4 : 32'd0);
        end else begin
            if (bus.EXLClr) m_sr = m_sr & ~32'h2;
            if (bus.WE && bus.A2 == 5'd12) m_sr = bus.DIn & SR_MASK;
            if (bus.WE && bus.A2 == 5'd14) m_epc = bus.DIn;
        end
    endtask

    initial begin
        //            a1     a2     din           we    vpc           bd    code   hw      clr   req   dout          epc
        tbl[0]  = mk(5'd12, 5'd12, 32'h0000_0401, 1'b1, 32'h0,        1'b0, 5'd0,  6'h00, 1'b0, 1'b0, 32'h0,        32'h0);
        tbl[1]  = mk(5'd12, 5'd0,  32'h0,        1'b0, 32'h3010,     1'b0, 5'd0,  6'h01, 1'b0, 1'b1, 32'h0000_0401, 32'h0);
        tbl[2]  = mk(5'd13, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 5'd0,  6'h01, 1'b0, 1'b0, 32'h0000_0400, 32'h3010);
        tbl[3]  = mk(5'd12, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 5'd0,  6'h01, 1'b0, 1'b0, 32'h0000_0403, 32'h3010);
        tbl[4]  = mk(5'd14, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 5'd0,  6'h00, 1'b0, 1'b0, 32'h0000_3010, 32'h3010);
        tbl[5]  = mk(5'd12, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 5'd0,  6'h00, 1'b1, 1'b0, 32'h0000_0403, 32'h3010);
        tbl[6]  = mk(5'd12, 5'd0,  32'h0,        1'b0, 32'h3024,     1'b1, 5'd12, 6'h00, 1'b0, 1'b1, 32'h0000_0401, 32'h3010);
        tbl[7]  = mk(5'd13, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 5'd0,  6'h00, 1'b0, 1'b0, 32'h8000_0030, 32'h3020);
        tbl[8]  = mk(5'd14, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 5'd0,  6'h00, 1'b0, 1'b0, 32'h0000_3020, 32'h3020);
        tbl[9]  = mk(5'd12, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 5'd0,  6'h01, 1'b1, 1'b0, 32'h0000_0403, 32'h3020);
        tbl[10] = mk(5'd13, 5'd14, 32'hDEAD,     1'b1, 32'h3100,     1'b0, 5'd4,  6'h01, 1'b0, 1'b1, 32'h8000_0430, 32'h3020);
        tbl[11] = mk(5'd13, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 5'd0,  6'h00, 1'b0, 1'b0, 32'h0000_0400, 32'h3100);
        tbl[12] = mk(5'd14, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 5'd0,  6'h00, 1'b0, 1'b0, 32'h0000_3100, 32'h3100);
        tbl[13] = mk(5'd14, 5'd14, 32'h4000,     1'b1, 32'h0,        1'b0, 5'd0,  6'h00, 1'b0, 1'b0, 32'h0000_3100, 32'h3100);
        tbl[14] = mk(5'd14, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 5'd0,  6'h00, 1'b0, 1'b0, 32'h0000_4000, 32'h4000);
        tbl[15] = mk(5'd12, 5'd12, 32'h0000_FC03, 1'b1, 32'h0,       1'b0, 5'd0,  6'h00, 1'b1, 1'b0, 32'h0000_0403, 32'h4000);
        tbl[16] = mk(5'd12, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 5'd0,  6'h3F, 1'b0, 1'b0, 32'h0000_FC03, 32'h4000);
        tbl[17] = mk(5'd15, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 5'd5,  6'h00, 1'b0, 1'b0, 32'h2023_0007, 32'h4000);
        tbl[18] = mk(5'd3,  5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 5'd0,  6'h00, 1'b1, 1'b0, 32'h0,        32'h4000);
        tbl[19] = mk(5'd12, 5'd13, 32'hFFFF_FFFF, 1'b1, 32'h0,       1'b0, 5'd0,  6'h00, 1'b0, 1'b0, 32'h0000_FC01, 32'h4000);
        tbl[20] = mk(5'd13, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 5'd0,  6'h00, 1'b0, 1'b0, 32'h0,        32'h4000);
        tbl[21] = mk(5'd14, 5'd0,  32'h0,        1'b0, 32'h0,        1'b1, 5'd10, 6'h00, 1'b0, 1'b1, 32'h0000_4000, 32'h4000);
        tbl[22] = mk(5'd14, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 5'd0,  6'h00, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
        tbl[23] = mk(5'd13, 5'd0,  32'h0,        1'b0, 32'h0,        1'b0, 5'd0,  6'h00, 1'b0, 1'b0, 32'h8000_0028, 32'hFFFF_FFFC);

        // Reset state
        drive(mk(5'd12, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 6'h3F, 1'b0, 1'b0, 32'h0, 32'h0));
        #2;
        chk("rst_req", {31'd0, bus.Req}, 32'h0);
        chk("rst_sr", bus.DOut, 32'h0);
        chk("rst_epcout", bus.EPCOut, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 24; i++) begin
            logic [31:0] exp_epc;
            drive(tbl[i]);
            exp_epc = tbl[i].epc;
`ifdef CP0_EPC_BYPASS_EN
            if (tbl[i].we && tbl[i].a2 == 5'd14 && !tbl[i].req) exp_epc = tbl[i].din;
`endif
            @(negedge clk);
            chk($sformatf("vec%0d_req", i), {31'd0, bus.Req}, {31'd0, tbl[i].req});
            chk($sformatf("vec%0d_dout", i), bus.DOut, tbl[i].dout);
            chk($sformatf("vec%0d_epcout", i), bus.EPCOut, exp_epc);
            @(posedge clk); #1;
        end

        // Async reset mid-handler: SR=FC03, EPC=FFFFFFFC; clear without a clock edge.
        drive(mk(5'd12, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 6'h01, 1'b0, 1'b0, 32'h0, 32'h0));
        #1;
        chk("pre_rst_sr", bus.DOut, 32'h0000_FC03);
        reset_n = 1'b0;
        #1;
        chk("arst_sr", bus.DOut, 32'h0);
        chk("arst_req", {31'd0, bus.Req}, 32'h0);
        bus.A1 = 5'd13; #1;
        chk("arst_cause", bus.DOut, 32'h0);
        bus.A1 = 5'd14; #1;
        chk("arst_epc", bus.DOut, 32'h0);
        chk("arst_epcout", bus.EPCOut, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        m_sr = 32'h0; m_cause = 32'h0; m_epc = 32'h0;
        @(posedge clk); #1;

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [4:0] codes[8];
            codes = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd4, 5'd5, 5'd10, 5'd12};
            bus.A1        = 5'($urandom_range(10, 17));
            bus.A2        = 5'($urandom_range(11, 15));
            bus.WE        = ($urandom_range(0, 2) == 0);
            bus.DIn       = $urandom;
            bus.VPC       = ($urandom_range(0, 15) == 0) ? 32'h0 : $urandom;
            bus.BDIn      = 1'($urandom_range(0, 1));
            bus.ExcCodeIn = codes[$urandom_range(0, 7)];
            bus.HWInt     = ($urandom_range(0, 1) == 0) ? 6'h00 : 6'($urandom);
            bus.EXLClr    = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            chk($sformatf("rnd%0d_req", n), {31'd0, bus.Req}, {31'd0, m_req()});
            chk($sformatf("rnd%0d_dout_a%0d", n, bus.A1), bus.DOut, m_dout());
            chk($sformatf("rnd%0d_epcout", n), bus.EPCOut, m_epcout());
            m_step();
            @(posedge clk); #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
- Coprocessor-0 exception/interrupt controller for the 5-stage MIPS pipeline. Holds SR, Cause, EPC and PRId.
- Decides exception/interrupt entry and drives Req and EPC to the D-stage next-PC logic, which jumps to 0x0000_4180 on Req and returns via EPC on eret.
- Sits at the M stage; serves mfc0/mtc0 and eret EXL clear.

Parameters:
- PRID_VALUE, 32'h2023_0007, read-only value returned for register 15.
- HWINT_W, 6, number of hardware interrupt lines (IM/IP width).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- A1  in  5  mfc0 read register number.
- A2  in  5  mtc0 write register number.
- DIn  in  32  mtc0 write data.
- WE  in  1  mtc0 write enable (M stage).
- VPC  in  32  PC of the M-stage (victim) instruction.
- BDIn  in  1  victim instruction is in a branch delay slot.
- ExcCodeIn  in  5  pipeline exception code; 0 means none.
- HWInt  in  HWINT_W  external interrupt lines, level-sensitive.
- EXLClr  in  1  eret in flight; clears SR.EXL.
- DOut  out  32  mfc0 read data (combinational).
- EPCOut  out  32  EPC to next-PC logic.
- Req  out  1  take exception/interrupt this cycle (combinational).

Behaviour:
- Reset (async, reset_n=0): SR=0, Cause=0, EPC=0. Outputs: Req=0, DOut=0 for A1 in {12,13,14}, EPCOut=0.
- SR(12) implements IM[15:10], EXL[1], IE[0]; all other bits read 0.
- Cause(13) implements BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0. Cause is read-only to mtc0.
- EPC(14) is 32 bits, fully writable. PRId(15) returns PRID_VALUE. Any other A1 reads 0.
- IntReq = |(HWInt & SR.IM) & SR.IE & ~SR.EXL.
- ExcReq = (ExcCodeIn != 0) & ~SR.EXL.
- Req = IntReq | ExcReq.
- Cause.IP <= HWInt every cycle, regardless of Req or EXL.
- On Req, at the rising edge:
  - SR.EXL <= 1.
  - Cause.BD <= BDIn.
  - Cause.ExcCode <= IntReq ? 0 : ExcCodeIn. Interrupt has priority over exception.
  - EPC <= BDIn ? VPC-4 : VPC. Arithmetic is 32-bit wrap.
- mtc0: when WE & ~Req, A2=12 writes the SR implemented bits from DIn; A2=14 writes EPC <= DIn. Other A2 values are ignored.
- EXLClr & ~Req: SR.EXL <= 0 at the next edge.
- Simultaneous events:
  - Req beats WE: the write is dropped.
  - Req beats EXLClr: EXL stays 1.
  - WE to SR together with EXLClr: the EXL bit written by DIn wins over EXLClr.
- While EXL=1, no new Req is raised (no nesting). ExcCodeIn is ignored.
- reset_n asserted mid-handler returns all state to reset immediately, without waiting for a clock edge.
- DOut is combinational from current state. It does not reflect a same-cycle write.

Optional Feature:
- Macro: CP0_EPC_BYPASS_EN.
- Defined: EPCOut = (WE & ~Req & A2==14) ? DIn : EPC. This lets an eret immediately following an mtc0 EPC use the new value with no stall.
- Undefined: EPCOut = EPC. The hazard unit must stall eret while an mtc0 to register 14 is in E or M.

Decomposition:
- Shared package (macro header) holds:
  - register numbers CP0_SR=12, CP0_CAUSE=13, CP0_EPC=14, CP0_PRID=15;
  - ExcCode constants Int=0, AdEL=4, AdES=5, RI=10, Ov=12;
  - exception entry address 32'h0000_4180, consumed by next-PC logic.
- The module is a single block, with no sub-module.

Test Plan:
- Reset: reset_n=0 mid-run with SR=32'h0000_FC01 -> SR, Cause and EPC read 0 immediately; Req=0.
- Interrupt: write SR=32'h0000_0401, set HWInt=6'b000001, VPC=32'h3010, BDIn=0 -> Req=1 same cycle. Next cycle: EPC=32'h3010, Cause=32'h0000_0400, SR.EXL=1, Req=0.
- Delay-slot exception: ExcCodeIn=12, VPC=32'h3024, BDIn=1 -> EPC=32'h3020, Cause[31]=1, Cause[6:2]=12.
- Priority and collision: interrupt enabled and pending, ExcCodeIn=4, WE=1, A2=14, DIn=32'hDEAD in the same cycle -> ExcCode=0; EPC=VPC, not 32'hDEAD.
- eret with EXL=1 and EXLClr=1 -> next cycle EXL=0; a pending masked-in interrupt raises Req that cycle.
- Bypass (macro on): WE=1, A2=14, DIn=32'h4000 -> EPCOut=32'h4000 the same cycle. With the macro off -> old EPC until the next edge.
